// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// The instruction and the datapath status flags flow in; the mux selects and strobes flow out.
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [31:0]           instr;
    logic                  alu_zero;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  ir_write;
    logic                  adr_src;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [2:0]            imm_sel;
    logic [1:0]            result_src;
    logic                  illegal_instr;

    modport master (
        input  instr, alu_zero, mem_ready,
        output pc_write, ir_write, adr_src, memread, memwrite, regwrite,
               alu_src_a, alu_src_b, alu_control, imm_sel, result_src, illegal_instr
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  pc_write, ir_write, adr_src, memread, memwrite, regwrite,
               alu_src_a, alu_src_b, alu_control, imm_sel, result_src, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: sequences fetch, decode, execute, memory and
// writeback, and parks in a trap state on unsupported instructions until reset.
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALU_CTRL_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    logic [2:0] state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt_op;
    logic       mem_done;
    logic       legal_op;
    logic       br_taken;
    logic [3:0] arith_op;
    logic       unused_instr_bits;

    logic       pc_write, ir_write, adr_src, memread, memwrite, regwrite;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign alt_op   = bus.instr[30];
    assign mem_done = (MEM_HANDSHAKE == 0) || bus.mem_ready;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    // Shared by R-type and I-arith; the R-type subtract case is layered on top.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt_op ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000, 3'b101, 3'b111: br_taken = bus.alu_zero;
            3'b001, 3'b100, 3'b110: br_taken = !bus.alu_zero;
            default:                br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_I;
        result_src = 2'd0;
        case (state_q)
            S_FETCH: begin
                memread   = 1'b1;
                alu_src_b = 2'd2;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_sel   = IMM_B;
                state_d   = legal_op ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                case (opcode)
                    OP_R: begin
                        alu_src_a = 2'd2;
                        alu_op    = (funct3 == 3'b000 && alt_op) ? ALU_SUB : arith_op;
                    end
                    OP_I: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        alu_op    = arith_op;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            state_d = S_TRAP;
                        end else begin
                            alu_src_a = 2'd2;
                            alu_op    = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                            pc_write  = br_taken;
                            state_d   = S_FETCH;
                        end
                    end
                    OP_JAL: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        imm_sel   = IMM_J;
                        pc_write  = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        pc_write  = 1'b1;
                    end
                    OP_LUI: imm_sel = IMM_U;
                    OP_AUIPC: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        imm_sel   = IMM_U;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                adr_src  = 1'b1;
                memread  = (opcode == OP_LOAD);
                memwrite = (opcode == OP_STORE);
                if (mem_done) state_d = (opcode == OP_STORE) ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                regwrite = 1'b1;
                case (opcode)
                    OP_LOAD:         result_src = 2'd1;
                    OP_JAL, OP_JALR: result_src = 2'd2;
                    OP_LUI:          result_src = 2'd3;
                    default:         result_src = 2'd0;
                endcase
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Strobes are suppressed while reset is held, so an interrupted store never writes.
    assign bus.pc_write      = pc_write & ~reset;
    assign bus.ir_write      = ir_write & ~reset;
    assign bus.memwrite      = memwrite & ~reset;
    assign bus.regwrite      = regwrite & ~reset;
    assign bus.memread       = memread;
    assign bus.adr_src       = adr_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_control   = ALU_CTRL_W'(alu_op);
    assign bus.imm_sel       = imm_sel;
    assign bus.result_src    = result_src;
    assign bus.illegal_instr = (state_q == S_TRAP);
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle sequences are
// predicted from instruction class and compared every cycle by an independent monitor.
module tb_multicycle_controller;
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [2:0] imm_sel;
        logic [1:0] result_src;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t exp;
        ctl_t mask;
        logic both;
    } sb_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
    localparam int K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9, K_BADBR = 10;
    // ALU code per funct3 for the plain (non-alternate) arithmetic operations
    localparam logic [31:0] BASE_OPS = {4'd2, 4'd3, 4'd8, 4'd5, 4'd6, 4'd4, 4'd7, 4'd0};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sb_t   exp_q[$];
    string nm_q[$];
    sb_t   cur;
    string cur_nm;
    ctl_t  act1, act2;

    multicycle_controller_if #(.ALU_CTRL_W(4)) bus1 ();
    multicycle_controller_if #(.ALU_CTRL_W(4)) bus2 ();

    assign bus2.instr     = bus1.instr;
    assign bus2.alu_zero  = bus1.alu_zero;
    assign bus2.mem_ready = 1'b0;

    multicycle_controller #(.MEM_HANDSHAKE(1), .ALU_CTRL_W(4)) dut_hs (
        .clk(clk), .reset(reset), .bus(bus1.master));
    multicycle_controller #(.MEM_HANDSHAKE(0), .ALU_CTRL_W(4)) dut_nohs (
        .clk(clk), .reset(reset), .bus(bus2.master));

    always #5 clk = ~clk;

    assign act1 = {bus1.pc_write, bus1.ir_write, bus1.adr_src, bus1.memread, bus1.memwrite,
                   bus1.regwrite, bus1.alu_src_a, bus1.alu_src_b, bus1.alu_control,
                   bus1.imm_sel, bus1.result_src, bus1.illegal_instr};
    assign act2 = {bus2.pc_write, bus2.ir_write, bus2.adr_src, bus2.memread, bus2.memwrite,
                   bus2.regwrite, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_control,
                   bus2.imm_sel, bus2.result_src, bus2.illegal_instr};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur    = exp_q.pop_front();
            cur_nm = nm_q.pop_front();
            checks++;
            if ((act1 & cur.mask) !== (cur.exp & cur.mask)) begin
                errors++;
                $display("FAIL %s (handshake dut): got %h want %h mask %h", cur_nm, act1, cur.exp, cur.mask);
            end
            if (cur.both) begin
                checks++;
                if ((act2 & cur.mask) !== (cur.exp & cur.mask)) begin
                    errors++;
                    $display("FAIL %s (no-handshake dut): got %h want %h mask %h", cur_nm, act2, cur.exp, cur.mask);
                end
            end
            checks++;
            if (bus1.regwrite && bus1.memwrite) begin
                errors++;
                $display("FAIL %s regwrite/memwrite overlap: got 1/1 want not both", cur_nm);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int classify(input logic [31:0] in);
        case (in[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return (in[14:13] == 2'b01) ? K_BADBR : K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input int k);
        logic [31:0] r = $urandom;
        case (k)
            K_R:     r[6:0] = 7'b0110011;
            K_I:     r[6:0] = 7'b0010011;
            K_LD:    r[6:0] = 7'b0000011;
            K_ST:    r[6:0] = 7'b0100011;
            K_JAL:   r[6:0] = 7'b1101111;
            K_JALR:  r[6:0] = 7'b1100111;
            K_LUI:   r[6:0] = 7'b0110111;
            K_AUIPC: r[6:0] = 7'b0010111;
            K_BR: begin
                r[6:0] = 7'b1100011;
                while (r[14:13] == 2'b01) r[14:12] = 3'($urandom);
            end
            K_BADBR: begin
                r[6:0]   = 7'b1100011;
                r[14:13] = 2'b01;
            end
            default: while (classify(r) != K_BAD) r[6:0] = 7'($urandom);
        endcase
        return r;
    endfunction

    function automatic ctl_t v_fetch(input logic done);
        ctl_t c = '0;
        c.memread   = 1'b1;
        c.alu_src_b = 2'd2;
        c.ir_write  = done;
        c.pc_write  = done;
        return c;
    endfunction

    function automatic ctl_t v_decode();
        ctl_t c = '0;
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd1;
        c.imm_sel   = 3'd2;
        return c;
    endfunction

    function automatic ctl_t v_trap();
        ctl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    function automatic ctl_t no_strobes(input ctl_t c);
        ctl_t r = c;
        r.pc_write = 1'b0;
        r.ir_write = 1'b0;
        r.memwrite = 1'b0;
        r.regwrite = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] arith_alu(input logic [2:0] f3, input logic alt, input logic is_r);
        if (f3 == 3'd5 && alt) return 4'd9;
        if (f3 == 3'd0 && alt && is_r) return 4'd1;
        return BASE_OPS[f3*4 +: 4];
    endfunction

    function automatic ctl_t v_exec(input logic [31:0] in, input logic zero);
        ctl_t       c  = '0;
        logic [2:0] f3 = in[14:12];
        case (classify(in))
            K_R: begin c.alu_src_a = 2; c.alu_control = arith_alu(f3, in[30], 1'b1); end
            K_I: begin c.alu_src_a = 2; c.alu_src_b = 1; c.alu_control = arith_alu(f3, in[30], 1'b0); end
            K_LD: begin c.alu_src_a = 2; c.alu_src_b = 1; c.imm_sel = 0; end
            K_ST: begin c.alu_src_a = 2; c.alu_src_b = 1; c.imm_sel = 1; end
            K_BR: begin
                c.alu_src_a   = 2;
                c.alu_control = f3[2] ? (f3[1] ? 4'd6 : 4'd4) : 4'd1;
                c.pc_write    = (f3 inside {3'd0, 3'd5, 3'd7}) ? zero : !zero;
            end
            K_JAL:   begin c.alu_src_a = 1; c.alu_src_b = 1; c.imm_sel = 3; c.pc_write = 1; end
            K_JALR:  begin c.alu_src_a = 2; c.alu_src_b = 1; c.imm_sel = 0; c.pc_write = 1; end
            K_LUI:   c.imm_sel = 4;
            K_AUIPC: begin c.alu_src_a = 1; c.alu_src_b = 1; c.imm_sel = 4; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t exec_mask(input int k);
        ctl_t m = '1;
        if (k == K_I) m.alu_src_a = 2'd0;
        if (k == K_BADBR) begin
            m          = '0;
            m.pc_write = 1; m.ir_write = 1; m.memread = 1; m.memwrite = 1; m.regwrite = 1; m.illegal = 1;
        end
        return m;
    endfunction

    function automatic ctl_t v_mem(input int k);
        ctl_t c = '0;
        c.adr_src  = 1'b1;
        c.memread  = (k == K_LD);
        c.memwrite = (k == K_ST);
        return c;
    endfunction

    function automatic ctl_t v_wb(input int k);
        ctl_t c = '0;
        c.regwrite   = 1'b1;
        c.result_src = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
        return c;
    endfunction

    task automatic cyc(input ctl_t e, input ctl_t m, input logic rst, input logic mr,
                       input logic both, input string nm);
        sb_t s;
        reset          = rst;
        bus1.mem_ready = mr;
        s.exp  = e;
        s.mask = m;
        s.both = both;
        exp_q.push_back(s);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_then_reset(input logic both, input string nm);
        ctl_t m = '1;
        for (int i = 0; i < 12; i++) cyc(v_trap(), '1, 1'b0, 1'($urandom), both, {nm, ":trap"});
        m.illegal = 1'b0;
        cyc(v_trap(), m, 1'b1, 1'($urandom), both, {nm, ":trap_reset"});
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic zero, input int fs, input int ms,
                             input logic both, input string nm);
        int k = classify(ins);
        bus1.instr    = ins;
        bus1.alu_zero = zero;
        for (int i = 0; i < fs; i++) cyc(v_fetch(1'b0), '1, 1'b0, 1'b0, both, {nm, ":fetch_wait"});
        cyc(v_fetch(1'b1), '1, 1'b0, 1'b1, both, {nm, ":fetch"});
        cyc(v_decode(), '1, 1'b0, 1'($urandom), both, {nm, ":decode"});
        if (k == K_BAD) begin
            trap_then_reset(both, nm);
            return;
        end
        cyc(v_exec(ins, zero), exec_mask(k), 1'b0, 1'($urandom), both, {nm, ":exec"});
        if (k == K_BADBR) begin
            trap_then_reset(both, nm);
            return;
        end
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < ms; i++) cyc(v_mem(k), '1, 1'b0, 1'b0, both, {nm, ":mem_wait"});
            cyc(v_mem(k), '1, 1'b0, 1'b1, both, {nm, ":mem"});
        end
        if (k != K_BR && k != K_ST) cyc(v_wb(k), '1, 1'b0, 1'($urandom), both, {nm, ":wb"});
    endtask

    task automatic store_reset_in_mem();
        logic [31:0] sw = {7'd0, 5'd2, 5'd3, 3'b010, 5'd4, 7'b0100011};
        bus1.instr    = sw;
        bus1.alu_zero = 1'b0;
        cyc(v_fetch(1'b1), '1, 1'b0, 1'b1, 1'b0, "sw_rst:fetch");
        cyc(v_decode(), '1, 1'b0, 1'b0, 1'b0, "sw_rst:decode");
        cyc(v_exec(sw, 1'b0), '1, 1'b0, 1'b0, 1'b0, "sw_rst:exec");
        cyc(v_mem(K_ST), '1, 1'b0, 1'b0, 1'b0, "sw_rst:mem_wait");
        cyc(v_mem(K_ST), '1, 1'b0, 1'b0, 1'b0, "sw_rst:mem_wait");
        cyc(no_strobes(v_mem(K_ST)), '1, 1'b1, 1'b1, 1'b0, "sw_rst:mem_in_reset");
        cyc(no_strobes(v_fetch(1'b1)), '1, 1'b1, 1'b1, 1'b0, "sw_rst:fetch_in_reset");
    endtask

    initial begin
        reset          = 1'b1;
        bus1.instr     = '0;
        bus1.alu_zero  = 1'b0;
        bus1.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(no_strobes(v_fetch(1'b1)), '1, 1'b1, 1'b1, 1'b1, "reset_fetch");
        cyc(no_strobes(v_fetch(1'b1)), '1, 1'b1, 1'b1, 1'b1, "reset_fetch2");

        // Handshake never stalls here, so both instances must follow the same trace.
        run_instr({12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}, 1'b0, 0, 0, 1'b1, "addi_x1_5");
        run_instr({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 1'b0, 0, 0, 1'b1, "sub");
        run_instr({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011}, 1'b0, 0, 0, 1'b1, "srai");
        run_instr({7'b0100000, 5'd3, 5'd1, 3'b000, 5'd3, 7'b0010011}, 1'b0, 0, 0, 1'b1, "addi_imm_hi");
        run_instr({7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 1'b0, 0, 0, 1'b1, "bne_taken");
        run_instr({7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 1'b1, 0, 0, 1'b1, "bne_not_taken");
        run_instr({25'd0, 7'b1111111}, 1'b0, 0, 0, 1'b1, "illegal_op");
        run_instr({20'h12345, 5'd7, 7'b0110111}, 1'b0, 0, 0, 1'b1, "lui_after_trap");
        for (int i = 0; i < 40; i++)
            run_instr(rand_instr($urandom_range(0, 10)), 1'($urandom), 0, 0, 1'b1, "rand_nostall");

        run_instr({12'd8, 5'd2, 3'b010, 5'd5, 7'b0000011}, 1'b0, 0, 3, 1'b0, "lw_stall3");
        store_reset_in_mem();
        run_instr({12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011}, 1'b0, 2, 0, 1'b0, "addi_after_rst");
        for (int i = 0; i < 60; i++)
            run_instr(rand_instr($urandom_range(0, 10)), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0, "rand_stall");

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
